// File: rtl/key_schedule_if.sv
// Handshake and data bundle between the key-schedule engine and the cipher datapath.
// Combinational bundle, no latency of its own.
// No backpressure: start and reads are single-cycle pulses; the engine never stalls the requester.
interface key_schedule_if #(
    parameter int K = 128
);
    logic           start;
    logic [K-1:0]   key;
    logic           busy;
    logic           ready;
    logic           rd_en;
    logic           rd_dec;
    logic [3:0]     rd_round;
    logic           rk_valid;
    logic           rk_err;
    logic [127:0]   roundKey;

    // Requester side (cipher datapath / controller)
    modport master (
        output start, key, rd_en, rd_dec, rd_round,
        input  busy, ready, rk_valid, rk_err, roundKey
    );

    // Engine side
    modport slave (
        input  start, key, rd_en, rd_dec, rd_round,
        output busy, ready, rk_valid, rk_err, roundKey
    );
endinterface

// File: rtl/key_schedule.sv
// AES key expansion (128/192/256) into an indexed round-key store; serves any round key in enc or dec order.
// Expansion NW-NK cycles (one word/cycle); read latency 1 cycle, back-to-back reads every cycle.
// No backpressure: start ignored while expanding; reads outside READY or beyond NR are flagged rk_err.
// Optional macro KEYSCHED_ZEROIZE_EN: reset and every accepted start clear the whole store.
module key_schedule #(
    parameter int K = 128
) (
    input  logic            i_clk,
    input  logic            i_reset,
    key_schedule_if.slave   bus
);
    localparam int NK = K / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);
    localparam logic [3:0] NR4 = 4'(NR);

    generate
        if (K != 128 && K != 192 && K != 256) begin : g_bad_key_len
            $error("key_schedule: K must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, inverse of 0 is 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t         r_state;
    logic [IW-1:0]  r_idx;      // next word index i to write
    logic [2:0]     r_mod;      // i mod NK, kept as a wrap counter
    logic [7:0]     r_rcon;
    logic           r_busy;
    logic           r_ready;
    logic           r_rk_valid;
    logic           r_rk_err;
    logic [127:0]   r_rk;
    logic [31:0]    r_store [NW];

    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_t;
    logic [31:0]    w_new;
    logic [3:0]     w_rnd;
    logic [IW-1:0]  w_base;
    logic           w_rd_ok;
    logic           w_load;
    logic [127:0]   w_rk;

    // Next schedule word: one shared 4-byte S-box path serves both the RotWord and plain SubWord cases
    always_comb begin
        w_prev   = r_store[r_idx - IW'(1)];
        w_back   = r_store[r_idx - IW'(NK)];
        w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub_out = '0;
        for (int b = 0; b < 4; b++) begin
            w_sub_out[8*b +: 8] = sbox(w_sub_in[8*b +: 8]);
        end
        if (r_mod == 3'd0)
            w_t = w_sub_out ^ {r_rcon, 24'h0};
        else if (K == 256 && r_mod == 3'd4)
            w_t = w_sub_out;
        else
            w_t = w_prev;
        w_new = w_back ^ w_t;
    end

    // Read path: map requested round to stored round, gather its four words
    always_comb begin
        w_rnd   = bus.rd_dec ? (NR4 - bus.rd_round) : bus.rd_round;
        w_base  = IW'({w_rnd, 2'b00});
        w_rd_ok = (r_state == READY) && (bus.rd_round <= NR4);
        w_load  = bus.start && (r_state != EXPAND);
        w_rk    = {r_store[w_base], r_store[w_base + IW'(1)],
                   r_store[w_base + IW'(2)], r_store[w_base + IW'(3)]};
    end

    // Control FSM with registered status and read outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_mod      <= '0;
            r_rcon     <= 8'h01;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_err   <= 1'b0;
            r_rk       <= '0;
        end else begin
            r_rk_valid <= 1'b0;
            r_rk_err   <= 1'b0;
            r_rk       <= '0;
            if (bus.rd_en) begin
                if (w_rd_ok) begin
                    r_rk_valid <= 1'b1;
                    r_rk       <= w_rk;
                end else begin
                    r_rk_err   <= 1'b1;
                end
            end
            case (r_state)
                EXPAND: begin
                    r_idx  <= r_idx + IW'(1);
                    r_mod  <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
                    if (r_mod == 3'd0)
                        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                    if (r_idx == IW'(NW - 1)) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        r_state <= EXPAND;
                        r_idx   <= IW'(NK);
                        r_mod   <= 3'd0;
                        r_rcon  <= 8'h01;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef KEYSCHED_ZEROIZE_EN
    // Word store: cleared on reset and on every accepted start, then key load / expansion writes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int j = 0; j < NW; j++) r_store[j] <= '0;
        end else if (w_load) begin
            for (int j = 0; j < NW; j++) r_store[j] <= '0;
            for (int j = 0; j < NK; j++) r_store[j] <= bus.key[K-1-32*j -: 32];
        end else if (r_state == EXPAND) begin
            r_store[r_idx] <= w_new;
        end
    end
`else
    // Word store without reset: key load on accepted start, one expanded word per EXPAND cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (w_load) begin
                for (int j = 0; j < NK; j++) r_store[j] <= bus.key[K-1-32*j -: 32];
            end else if (r_state == EXPAND) begin
                r_store[r_idx] <= w_new;
            end
        end
    end
`endif

    assign bus.busy     = r_busy;
    assign bus.ready    = r_ready;
    assign bus.rk_valid = r_rk_valid;
    assign bus.rk_err   = r_rk_err;
    assign bus.roundKey = r_rk;
endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: one instance per key length, FIPS-197 vectors.
// Checks expansion latency, enc/dec read ordering, rejected reads, restart and reset behaviour.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_key_schedule;
    logic clk;
    logic rst;

    key_schedule_if #(.K(128)) b128 ();
    key_schedule_if #(.K(192)) b192 ();
    key_schedule_if #(.K(256)) b256 ();

    key_schedule #(.K(128)) u128 (.i_clk(clk), .i_reset(rst), .bus(b128));
    key_schedule #(.K(192)) u192 (.i_clk(clk), .i_reset(rst), .bus(b192));
    key_schedule #(.K(256)) u256 (.i_clk(clk), .i_reset(rst), .bus(b256));

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_1     = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_rd(input int w, input logic en, input logic dec, input logic [3:0] rnd);
        case (w)
            128:     begin b128.rd_en = en; b128.rd_dec = dec; b128.rd_round = rnd; end
            192:     begin b192.rd_en = en; b192.rd_dec = dec; b192.rd_round = rnd; end
            default: begin b256.rd_en = en; b256.rd_dec = dec; b256.rd_round = rnd; end
        endcase
    endtask

    task automatic set_start(input int w, input logic s);
        case (w)
            128:     b128.start = s;
            192:     b192.start = s;
            default: b256.start = s;
        endcase
    endtask

    task automatic get_out(input int w, output logic v, output logic e, output logic [127:0] d,
                           output logic bsy, output logic rdy);
        case (w)
            128:     begin v = b128.rk_valid; e = b128.rk_err; d = b128.roundKey; bsy = b128.busy; rdy = b128.ready; end
            192:     begin v = b192.rk_valid; e = b192.rk_err; d = b192.roundKey; bsy = b192.busy; rdy = b192.ready; end
            default: begin v = b256.rk_valid; e = b256.rk_err; d = b256.roundKey; bsy = b256.busy; rdy = b256.ready; end
        endcase
    endtask

    // One read request, checked one cycle later
    task automatic do_read(input string tag, input int w, input logic dec, input logic [3:0] rnd,
                           input logic ev, input logic ee, input logic [127:0] ed);
        logic v, e, bsy, rdy;
        logic [127:0] d;
        set_rd(w, 1'b1, dec, rnd);
        @(negedge clk);
        get_out(w, v, e, d, bsy, rdy);
        set_rd(w, 1'b0, 1'b0, 4'd0);
        check_vec({tag, "_vld"}, 128'(v), 128'(ev));
        check_vec({tag, "_err"}, 128'(e), 128'(ee));
        check_vec({tag, "_dat"}, d, ed);
    endtask

    // Pulse start (key already driven), then count cycles until ready
    task automatic run_expand(input string tag, input int w, input int exp_cyc);
        logic v, e, bsy, rdy;
        logic [127:0] d;
        int cnt;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        get_out(w, v, e, d, bsy, rdy);
        check_vec({tag, "_busy_at_T"}, 128'(bsy), 128'd1);
        cnt = 0;
        while (!rdy && cnt < 200) begin
            @(negedge clk);
            cnt++;
            get_out(w, v, e, d, bsy, rdy);
        end
        check_vec({tag, "_ready_cycles"}, 128'(cnt), 128'(exp_cyc));
        check_vec({tag, "_busy_done"}, 128'(bsy), 128'd0);
    endtask

    initial begin
        logic v, e, bsy, rdy;
        logic [127:0] d;
        int cnt;

        rst = 1'b1;
        b128.start = 0; b128.key = '0; b128.rd_en = 0; b128.rd_dec = 0; b128.rd_round = 0;
        b192.start = 0; b192.key = '0; b192.rd_en = 0; b192.rd_dec = 0; b192.rd_round = 0;
        b256.start = 0; b256.key = '0; b256.rd_en = 0; b256.rd_dec = 0; b256.rd_round = 0;
        // a read held during reset must not raise rk_err
        b128.rd_en = 1'b1;
        repeat (3) @(negedge clk);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("reset_outputs", {v, e, bsy, rdy, d}, '0);
        b128.rd_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_read("idle_read", 128, 1'b0, 4'd0, 1'b0, 1'b1, '0);

        // K=128 expansion with a read and a second start injected mid-EXPAND
        b128.key = K128;
        set_start(128, 1'b1);
        @(negedge clk);
        set_start(128, 1'b0);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("k128_busy_at_T", {bsy, rdy}, 128'b10);
        cnt = 0;
        while (!rdy && cnt < 200) begin
            if (cnt == 5) begin b128.start = 1'b1; b128.key = ~K128; end
            if (cnt == 6) begin b128.start = 1'b0; b128.key = K128; end
            if (cnt == 10) set_rd(128, 1'b1, 1'b0, 4'd0);
            @(negedge clk);
            cnt++;
            get_out(128, v, e, d, bsy, rdy);
            if (cnt == 11) begin
                check_vec("busy_read", {v, e, d}, {1'b0, 1'b1, 128'h0});
                set_rd(128, 1'b0, 1'b0, 4'd0);
            end
        end
        check_vec("k128_ready_cycles", 128'(cnt), 128'd40);
        check_vec("k128_busy_done", 128'(bsy), 128'd0);

        do_read("k128_enc10", 128, 1'b0, 4'd10, 1'b1, 1'b0, R128_10);
        do_read("k128_dec0", 128, 1'b1, 4'd0, 1'b1, 1'b0, R128_10);
        do_read("k128_enc1", 128, 1'b0, 4'd1, 1'b1, 1'b0, R128_1);
        do_read("k128_dec9", 128, 1'b1, 4'd9, 1'b1, 1'b0, R128_1);
        do_read("k128_rnd15", 128, 1'b0, 4'd15, 1'b0, 1'b1, '0);
        do_read("k128_rnd11", 128, 1'b1, 4'd11, 1'b0, 1'b1, '0);

        // back-to-back reads, then output must drop after one cycle
        set_rd(128, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("b2b_first", d, K128);
        set_rd(128, 1'b1, 1'b1, 4'd0);
        @(negedge clk);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("b2b_second", d, R128_10);
        set_rd(128, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("b2b_drop", {v, e, d}, '0);

        // K=192
        b192.key = K192;
        run_expand("k192", 192, 46);
        do_read("k192_enc12", 192, 1'b0, 4'd12, 1'b1, 1'b0, R192_12);
        do_read("k192_dec0", 192, 1'b1, 4'd0, 1'b1, 1'b0, R192_12);
        do_read("k192_enc0", 192, 1'b0, 4'd0, 1'b1, 1'b0, R192_0);
        do_read("k192_rnd13", 192, 1'b0, 4'd13, 1'b0, 1'b1, '0);

        // K=256
        b256.key = K256;
        run_expand("k256", 256, 52);
        do_read("k256_enc14", 256, 1'b0, 4'd14, 1'b1, 1'b0, R256_14);
        do_read("k256_enc3", 256, 1'b0, 4'd3, 1'b1, 1'b0, R256_3);
        do_read("k256_dec0", 256, 1'b1, 4'd0, 1'b1, 1'b0, R256_14);
        do_read("k256_rnd15", 256, 1'b0, 4'd15, 1'b0, 1'b1, '0);

        // start and read in the same READY cycle: read sees the old schedule
        b128.key = '0;
        set_start(128, 1'b1);
        set_rd(128, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        set_start(128, 1'b0);
        set_rd(128, 1'b0, 1'b0, 4'd0);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("restart_old_key", {v, e, d}, {1'b1, 1'b0, K128});
        check_vec("restart_flags", {bsy, rdy}, 128'b10);
        cnt = 0;
        while (!rdy && cnt < 200) begin
            @(negedge clk);
            cnt++;
            get_out(128, v, e, d, bsy, rdy);
        end
        check_vec("restart_ready_cycles", 128'(cnt), 128'd40);
        do_read("zero_enc1", 128, 1'b0, 4'd1, 1'b1, 1'b0, Z_1);

        // reset at cycle 20 of EXPAND while a rejected read is pending
        b128.key = K128;
        set_start(128, 1'b1);
        @(negedge clk);
        set_start(128, 1'b0);
        cnt = 0;
        while (cnt < 20) begin
            if (cnt == 18) set_rd(128, 1'b1, 1'b0, 4'd0);
            if (cnt == 19) rst = 1'b1;
            @(negedge clk);
            cnt++;
            get_out(128, v, e, d, bsy, rdy);
            if (cnt == 19) check_vec("pre_reset_err", {bsy, e}, 128'b11);
        end
        check_vec("mid_reset_outputs", {v, e, bsy, rdy, d}, '0);
        rst = 1'b0;
        set_rd(128, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        get_out(128, v, e, d, bsy, rdy);
        check_vec("post_reset_idle", {bsy, rdy}, '0);

        // fresh expansion with an all-zero key
        b128.key = '0;
        run_expand("zero", 128, 40);
        do_read("zero_enc0", 128, 1'b0, 4'd0, 1'b1, 1'b0, '0);
        do_read("zero_enc10", 128, 1'b0, 4'd10, 1'b1, 1'b0, Z_10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
